// File: rtl/shift_serial_out.sv
`default_nettype none
// ============================================================================
//  Module      : shift_serial_out
//  Description : Parallel-in, serial-out transmitter. Captures a WIDTH-bit
//                word on load and presents it one bit per enabled clock on
//                serial_out, with shift_out qualifying each transmitted bit
//                for a downstream serial-in shift register.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_serial_out #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             shift,
  output logic             serial_out,
  output logic             shift_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_q_shifted;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_head;
  logic             w_sending;

  // Bit order selects which end of the register is on the wire and which way
  // the remaining bits move; vacated positions are zero-filled.
  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign w_head      = r_q[0];
      assign w_q_shifted = {1'b0, r_q[WIDTH-1:1]};
    end else begin : g_msb_first
      assign w_head      = r_q[WIDTH-1];
      assign w_q_shifted = {r_q[WIDTH-2:0], 1'b0};
    end
  endgenerate

  // State, shift register and bit counter; reset clears a partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: load accepted only in IDLE, one bit consumed per
  // enabled edge in SEND, DONE lasts a single cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (load) begin
          w_q_nxt     = data_in;
          w_cnt_nxt   = CW'(WIDTH);
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (shift) begin
          w_q_nxt   = w_q_shifted;
          w_cnt_nxt = r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs decode straight from state so reset forces them low at once.
  assign w_sending  = (r_state == S_SEND);
  assign busy       = w_sending;
  assign done       = (r_state == S_DONE);
  assign serial_out = w_sending & w_head;
  assign shift_out  = w_sending & shift;
  assign Q          = r_q;

endmodule
`default_nettype wire
